// File: rtl/sram_port_arbiter_if.sv
// Bundle of every signal between the arbiter, the two CPU requesters and the
// unified SRAM.
//
// Handshake: a requester raises X_req together with its address (and, for
// data, wen/wdata) and holds all of them stable until the cycle in which
// X_ack pulses for one cycle.  X_rdata is only meaningful while X_ack is high
// and reads as zero otherwise.  The requester may drop or change the request
// in the cycle after the ack.  The SRAM side is a plain strobe: sram_en with
// address/wen/wdata in cycle N, sram_rdata valid in cycle N+1.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_ack;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic [3:0]        data_wen;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_ack;
    logic [DATA_W-1:0] data_rdata;

    logic              sram_en;
    logic [3:0]        sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    logic              stall;
    logic [CNT_W-1:0]  conflict_cnt;

    // Arbiter view.
    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wen, data_addr, data_wdata,
        input  sram_rdata,
        output inst_ack, inst_rdata,
        output data_ack, data_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata,
        output stall, conflict_cnt
    );

    // Requester / memory view.
    modport master (
        output inst_req, inst_addr,
        output data_req, data_wen, data_addr, data_wdata,
        output sram_rdata,
        input  inst_ack, inst_rdata,
        input  data_ack, data_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata,
        input  stall, conflict_cnt
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between the instruction-fetch and
// data-access ports.  One access issues per cycle, its ack/data return the
// following cycle, contests are resolved round-robin and counted.
module sram_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input logic                clk,
    input logic                resetn,
    sram_port_arbiter_if.slave bus
);

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    // Outstanding access (returns next cycle) and round-robin history.
    logic             out_valid_q,  out_valid_d;
    owner_e           out_owner_q,  out_owner_d;
    logic             out_write_q,  out_write_d;
    owner_e           last_grant_q, last_grant_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    logic   inst_elig;
    logic   data_elig;
    logic   contest;
    logic   grant;
    owner_e winner;
    logic   inst_ack_w;
    logic   data_ack_w;

    // Eligibility and winner; a port in its own return cycle is not
    // eligible, so its still-held request is not issued a second time.
    always_comb begin
        inst_elig = bus.inst_req && !(out_valid_q && (out_owner_q == OWN_INST));
        data_elig = bus.data_req && !(out_valid_q && (out_owner_q == OWN_DATA));
        contest   = inst_elig && data_elig;
        grant     = inst_elig || data_elig;
        if (contest) begin
            winner = (last_grant_q == OWN_INST) ? OWN_DATA : OWN_INST;
        end else if (data_elig) begin
            winner = OWN_DATA;
        end else begin
            winner = OWN_INST;
        end
    end

    // Drive the SRAM with the winner's access; quiet zeros when idle.
    always_comb begin
        bus.sram_en    = 1'b0;
        bus.sram_wen   = 4'd0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        if (grant) begin
            bus.sram_en = 1'b1;
            if (winner == OWN_DATA) begin
                bus.sram_wen   = bus.data_wen;
                bus.sram_addr  = bus.data_addr;
                bus.sram_wdata = bus.data_wdata;
            end else begin
                bus.sram_addr  = bus.inst_addr;
            end
        end
    end

    // Return path: ack the owner of last cycle's access, route read data
    // only to it and only for reads; stall while any request is unserved.
    always_comb begin
        inst_ack_w       = out_valid_q && (out_owner_q == OWN_INST);
        data_ack_w       = out_valid_q && (out_owner_q == OWN_DATA);
        bus.inst_ack     = inst_ack_w;
        bus.data_ack     = data_ack_w;
        bus.inst_rdata   = (inst_ack_w && !out_write_q) ? bus.sram_rdata : '0;
        bus.data_rdata   = (data_ack_w && !out_write_q) ? bus.sram_rdata : '0;
        bus.stall        = (bus.inst_req && !inst_ack_w) || (bus.data_req && !data_ack_w);
        bus.conflict_cnt = conflict_cnt_q;
    end

    // Next state of the outstanding-access record, history and counter.
    always_comb begin
        out_valid_d    = grant;
        out_owner_d    = winner;
        out_write_d    = (winner == OWN_DATA) && (bus.data_wen != 4'd0);
        last_grant_d   = grant ? winner : last_grant_q;
        conflict_cnt_d = conflict_cnt_q;
        if (contest && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset discards any outstanding access and makes the
    // data port win the first contest.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q    <= 1'b0;
            out_owner_q    <= OWN_INST;
            out_write_q    <= 1'b0;
            last_grant_q   <= OWN_INST;
            conflict_cnt_q <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_owner_q    <= out_owner_d;
            out_write_q    <= out_write_d;
            last_grant_q   <= last_grant_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) bus ();
    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(4))  bus4 ();

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut4 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus4)
    );

    // The narrow-counter instance sees exactly the same traffic.
    assign bus4.inst_req   = bus.inst_req;
    assign bus4.inst_addr  = bus.inst_addr;
    assign bus4.data_req   = bus.data_req;
    assign bus4.data_wen   = bus.data_wen;
    assign bus4.data_addr  = bus.data_addr;
    assign bus4.data_wdata = bus.data_wdata;
    assign bus4.sram_rdata = bus.sram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who gets data back this cycle, who won the last
    // grant (1 = inst, 2 = data), total contested cycles, expected return data.
    int          ret_owner = 0;
    int          last_win  = 1;
    int          cnt_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem[16];

    // Memory environment (acts on what the DUT actually drives).
    logic [31:0] sram_mem[16];
    logic [31:0] sram_rdata_nxt;

    // Observed values of the last step, used by the drivers and directed checks.
    logic        obs_iack, obs_dack, obs_en, obs_stall;
    logic [3:0]  obs_wen;
    logic [31:0] obs_addr, obs_wdata, obs_irdata, obs_drdata, obs_cnt32, obs_cnt4;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, advance model and memory,
    // then return just after the next rising edge for the caller to drive.
    task automatic step();
        bit          ack_i, ack_d, ei, ed;
        int          win;
        logic [31:0] e_rdata, e_addr, e_wdata, e_cnt4, rd;
        logic [3:0]  e_wen, idx;
        @(negedge clk);
        if (!resetn) begin
            ret_owner = 0;
            last_win  = 1;
            cnt_total = 0;
            exp_q.delete();
        end
        ack_i   = (ret_owner == 1);
        ack_d   = (ret_owner == 2);
        e_rdata = '0;
        if (ret_owner != 0 && exp_q.size() > 0) e_rdata = exp_q.pop_front();
        ei  = bus.inst_req && !ack_i;
        ed  = bus.data_req && !ack_d;
        win = 0;
        if (ei && ed)   win = (last_win == 2) ? 1 : 2;
        else if (ed)    win = 2;
        else if (ei)    win = 1;
        e_wen   = (win == 2) ? bus.data_wen : 4'd0;
        e_addr  = (win == 2) ? bus.data_addr : ((win == 1) ? bus.inst_addr : 32'd0);
        e_wdata = (win == 2) ? bus.data_wdata : 32'd0;
        e_cnt4  = (cnt_total > 15) ? 32'd15 : 32'(cnt_total);

        check_eq("inst_ack",   32'(bus.inst_ack), 32'(ack_i));
        check_eq("data_ack",   32'(bus.data_ack), 32'(ack_d));
        check_eq("inst_rdata", bus.inst_rdata, ack_i ? e_rdata : 32'd0);
        check_eq("data_rdata", bus.data_rdata, ack_d ? e_rdata : 32'd0);
        check_eq("sram_en",    32'(bus.sram_en), 32'(win != 0));
        check_eq("sram_wen",   32'(bus.sram_wen), 32'(e_wen));
        check_eq("sram_addr",  bus.sram_addr, e_addr);
        check_eq("sram_wdata", bus.sram_wdata, e_wdata);
        check_eq("stall",      32'(bus.stall),
                 32'((bus.inst_req && !ack_i) || (bus.data_req && !ack_d)));
        check_eq("conflict_cnt32", bus.conflict_cnt, 32'(cnt_total));
        check_eq("conflict_cnt4",  32'(bus4.conflict_cnt), e_cnt4);

        obs_iack = bus.inst_ack;   obs_dack = bus.data_ack;
        obs_en = bus.sram_en;      obs_stall = bus.stall;
        obs_wen = bus.sram_wen;    obs_addr = bus.sram_addr;
        obs_wdata = bus.sram_wdata;
        obs_irdata = bus.inst_rdata; obs_drdata = bus.data_rdata;
        obs_cnt32 = bus.conflict_cnt; obs_cnt4 = 32'(bus4.conflict_cnt);

        // Memory: idle cycles return garbage so leaked data shows up.
        sram_rdata_nxt = $urandom();
        if (bus.sram_en) begin
            idx = bus.sram_addr[5:2];
            sram_rdata_nxt = sram_mem[idx];
            for (int b = 0; b < 4; b++)
                if (bus.sram_wen[b]) sram_mem[idx][8*b +: 8] = bus.sram_wdata[8*b +: 8];
        end

        // Reference model clock edge.
        if (resetn && win != 0) begin
            idx = e_addr[5:2];
            rd  = ref_mem[idx];
            exp_q.push_back((win == 2 && e_wen != 4'd0) ? 32'd0 : rd);
            for (int b = 0; b < 4; b++)
                if (e_wen[b]) ref_mem[idx][8*b +: 8] = e_wdata[8*b +: 8];
            last_win = win;
        end
        ret_owner = resetn ? win : 0;
        if (resetn && ei && ed) cnt_total++;

        @(posedge clk);
        #1;
        bus.sram_rdata = sram_rdata_nxt;
    endtask

    // Requesters obeying the protocol: hold until ack, then maybe re-request.
    task automatic drive_random(input int pct);
        logic [31:0] r;
        if (!bus.inst_req || obs_iack) begin
            r = $urandom();
            bus.inst_req  = ($urandom_range(99) < pct);
            bus.inst_addr = {r[31:6], 4'($urandom_range(15)), 2'b00};
        end
        if (!bus.data_req || obs_dack) begin
            r = $urandom();
            bus.data_req   = ($urandom_range(99) < pct);
            bus.data_addr  = {r[31:6], 4'($urandom_range(15)), 2'b00};
            bus.data_wen   = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
            bus.data_wdata = $urandom();
        end
    endtask

    task automatic drop_all();
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
        bus.data_wen = 4'd0;
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        drop_all();
        step();
        check_eq("rst_sram_en", 32'(obs_en), 32'd0);
        check_eq("rst_stall",   32'(obs_stall), 32'd0);
        check_eq("rst_cnt",     obs_cnt32, 32'd0);
        resetn = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            sram_mem[k] = $urandom();
            ref_mem[k]  = sram_mem[k];
        end
        sram_mem[0] = 32'h2401_0001;
        ref_mem[0]  = 32'h2401_0001;
        bus.inst_req = 1'b0;   bus.inst_addr = '0;
        bus.data_req = 1'b0;   bus.data_wen = 4'd0;
        bus.data_addr = '0;    bus.data_wdata = '0;
        bus.sram_rdata = '0;

        repeat (2) @(posedge clk);
        #1;
        step();
        resetn = 1'b1;
        repeat (3) step();
        check_eq("idle_sram_en", 32'(obs_en), 32'd0);

        // First contest after reset: data wins, inst follows.
        bus.inst_req = 1'b1;  bus.inst_addr = 32'hBFC0_0004;
        bus.data_req = 1'b1;  bus.data_addr = 32'h8000_0000; bus.data_wen = 4'd0;
        step();
        check_eq("contest_first_addr", obs_addr, 32'h8000_0000);
        step();
        check_eq("contest_data_ack", 32'(obs_dack), 32'd1);
        check_eq("contest_inst_addr", obs_addr, 32'hBFC0_0004);
        check_eq("contest_cnt_n1", obs_cnt32, 32'd1);
        bus.data_req = 1'b0;
        step();
        check_eq("contest_inst_ack", 32'(obs_iack), 32'd1);
        check_eq("contest_cnt_n2", obs_cnt32, 32'd1);
        bus.inst_req = 1'b0;
        step();

        // Lone fetch.
        bus.inst_req = 1'b1;  bus.inst_addr = 32'hBFC0_0000;
        step();
        check_eq("fetch_en",    32'(obs_en), 32'd1);
        check_eq("fetch_addr",  obs_addr, 32'hBFC0_0000);
        check_eq("fetch_stall", 32'(obs_stall), 32'd1);
        step();
        check_eq("fetch_ack",   32'(obs_iack), 32'd1);
        check_eq("fetch_rdata", obs_irdata, 32'h2401_0001);
        check_eq("fetch_stall_ack", 32'(obs_stall), 32'd0);
        bus.inst_req = 1'b0;

        // Store.
        bus.data_req = 1'b1;  bus.data_wen = 4'b0011;
        bus.data_addr = 32'h8000_0010;  bus.data_wdata = 32'h1234_ABCD;
        step();
        check_eq("store_wen",   32'(obs_wen), 32'd3);
        check_eq("store_wdata", obs_wdata, 32'h1234_ABCD);
        step();
        check_eq("store_ack",   32'(obs_dack), 32'd1);
        check_eq("store_rdata", obs_drdata, 32'd0);
        drop_all();
        step();

        // Sustained contention: sram_en must stay high every cycle.
        for (int c = 0; c < 12; c++) begin
            drive_random(100);
            step();
            if (c > 0) check_eq("sustain_en", 32'(obs_en), 32'd1);
        end
        drop_all();
        step();

        // Reset landing in a return cycle: the ack is discarded.
        bus.data_req = 1'b1;  bus.data_addr = 32'h8000_0020;  bus.data_wen = 4'd0;
        step();
        resetn = 1'b0;
        drop_all();
        step();
        check_eq("rst_return_ack", 32'(obs_dack), 32'd0);
        resetn = 1'b1;
        step();

        // Twenty contested cycles: narrow counter saturates at 15.
        for (int r = 0; r < 20; r++) begin
            bus.inst_req = 1'b1;  bus.inst_addr = {26'h0, 4'($urandom_range(15)), 2'b00};
            bus.data_req = 1'b1;  bus.data_addr = {26'h0, 4'($urandom_range(15)), 2'b00};
            bus.data_wen = 4'd0;
            step();
            step();
            bus.data_req = 1'b0;
            step();
        end
        check_eq("sat_cnt32", obs_cnt32, 32'd20);
        check_eq("sat_cnt4",  obs_cnt4, 32'd15);
        drop_all();
        step();

        // Random traffic with periodic mid-stream resets.
        for (int c = 0; c < 600; c++) begin
            if (c % 150 == 149) begin
                pulse_reset();
            end else begin
                drive_random((c % 300 < 150) ? 70 : 40);
                step();
            end
        end
        drop_all();
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
